// File: rtl/acc_result_writeback_pkg.sv
// Shared types for the result writeback path: FSM states and the per-element requantiser.
// requant() works on a 64-bit sign/zero-extended value, which is exact for any ACC_W up to 62.
package acc_result_writeback_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_e;

    localparam int RQ_W = 64;

    typedef struct packed {
        logic            clipped;
        logic [RQ_W-1:0] y;
    } rq_t;

    function automatic rq_t requant(input logic signed [RQ_W-1:0] x,
                                    input logic [4:0]              shift,
                                    input int                      out_w,
                                    input logic                    is_signed,
                                    input logic                    sat);
        logic signed [RQ_W-1:0] y;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        rq_t r;
        if (shift == 5'd0) begin
            y = x;
        end else begin
            y = (x + (64'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        hi = is_signed ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
        lo = is_signed ? -(64'sd1 <<< (out_w - 1)) : 64'sd0;
        r.clipped = 1'b0;
        r.y       = y;
        if (sat && (y > hi)) begin
            r.clipped = 1'b1;
            r.y       = hi;
        end else if (sat && (y < lo)) begin
            r.clipped = 1'b1;
            r.y       = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_result_writeback_if.sv
// Row capture stream plus UB write port of the writeback path.
// slave = the writeback block; master = whoever feeds rows and owns the UB.
interface acc_result_writeback_if #(
    parameter int N_COLS = 3,
    parameter int ACC_W  = 32,
    parameter int UB_W   = 256,
    parameter int ADDR_W = 9
) ();
    logic                    cap_valid;
    logic [N_COLS*ACC_W-1:0] cap_data;
    logic                    cap_ready;
    logic                    ub_wr_en;
    logic [ADDR_W-1:0]       ub_wr_addr;
    logic [UB_W-1:0]         ub_wr_data;
    logic                    ub_wr_ready;

    modport master (
        output cap_valid, cap_data, ub_wr_ready,
        input  cap_ready, ub_wr_en, ub_wr_addr, ub_wr_data
    );

    modport slave (
        input  cap_valid, cap_data, ub_wr_ready,
        output cap_ready, ub_wr_en, ub_wr_addr, ub_wr_data
    );
endinterface

// File: rtl/acc_result_writeback_requant_lane.sv
// One column of requantisation: rounding shift then clamp/truncate to OUT_W; purely combinational.
// No handshake of its own; the parent registers the result.
module acc_result_writeback_requant_lane
    import acc_result_writeback_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] x,
    input  logic [4:0]       shift,
    input  logic             use_signed,
    input  logic             sat_en,
    output logic [OUT_W-1:0] y,
    output logic             clipped
);
    logic signed [RQ_W-1:0] x_ext;
    rq_t                    r;
    logic                   unused_hi;

    always_comb begin
        if (use_signed) begin
            x_ext = {{(RQ_W-ACC_W){x[ACC_W-1]}}, x};
        end else begin
            x_ext = {{(RQ_W-ACC_W){1'b0}}, x};
        end
        r = requant(x_ext, shift, OUT_W, use_signed, sat_en);
    end

    assign y         = r.y[OUT_W-1:0];
    assign clipped   = r.clipped;
    assign unused_hi = ^r.y[RQ_W-1:OUT_W];
endmodule

// File: rtl/acc_result_writeback.sv
// Drains result rows into consecutive UB words: skid FIFO -> requant/pack register -> UB; 2-cycle latency.
// UB backpressure holds the output word, fills the FIFO, then drops cap_ready; no row lost or duplicated.
module acc_result_writeback
    import acc_result_writeback_pkg::*;
#(
    parameter int N_COLS     = 3,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int UB_W       = 256,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [7:0]         num_rows,
    input  logic [4:0]         shift,
    input  logic               use_signed,
    input  logic               sat_en,
    acc_result_writeback_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic [15:0]        sat_count,
    output logic               err
);
    localparam int ROW_W  = N_COLS * ACC_W;
    localparam int PACK_W = N_COLS * OUT_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    wb_state_e state, state_nxt;

    logic [7:0]        num_lat;
    logic [4:0]        shift_lat;
    logic              signed_lat;
    logic              sat_lat;
    logic [7:0]        rows_acc;
    logic [7:0]        wr_cnt;
    logic [ADDR_W-1:0] addr_q;

    logic [ROW_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [ROW_W-1:0]  head;

    logic              out_vld;
    logic [UB_W-1:0]   out_dat;

    logic              start_acc, cap_rdy, cap_fire, ub_fire, pop;
    logic [OUT_W-1:0]  lane_y [N_COLS];
    logic [N_COLS-1:0] clip_vec;
    logic [PACK_W-1:0] packed_row;
    logic [15:0]       clip_cnt;
    logic [16:0]       sat_sum;

    assign start_acc = start && (state == IDLE);
    assign cap_rdy   = (state == RUN) && (rows_acc != num_lat) && (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign cap_fire  = bus.cap_valid && cap_rdy;
    assign ub_fire   = out_vld && bus.ub_wr_ready;
    // The output register reloads only once its current word has been taken.
    assign pop       = (fifo_cnt != '0) && (!out_vld || bus.ub_wr_ready);
    assign head      = fifo_mem[rd_ptr];

    assign bus.cap_ready  = cap_rdy;
    assign bus.ub_wr_en   = out_vld;
    assign bus.ub_wr_addr = addr_q;
    assign bus.ub_wr_data = out_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:  if (start) state_nxt = (num_rows == 8'd0) ? DONE : RUN;
            RUN:   if (cap_fire && (rows_acc == num_lat - 8'd1)) state_nxt = DRAIN;
            DRAIN: if (ub_fire && (wr_cnt == num_lat - 8'd1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat    <= '0;
            shift_lat  <= '0;
            signed_lat <= 1'b0;
            sat_lat    <= 1'b0;
            rows_acc   <= '0;
            wr_cnt     <= '0;
            addr_q     <= '0;
            err        <= 1'b0;
        end else begin
            if (start) err <= (state != IDLE);
            if (start_acc) begin
                num_lat    <= num_rows;
                shift_lat  <= shift;
                signed_lat <= use_signed;
                sat_lat    <= sat_en;
                rows_acc   <= '0;
                wr_cnt     <= '0;
                addr_q     <= base_addr;
            end else begin
                if (cap_fire) rows_acc <= rows_acc + 8'd1;
                if (ub_fire) begin
                    wr_cnt <= wr_cnt + 8'd1;
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_fire) fifo_mem[wr_ptr] <= bus.cap_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (cap_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            case ({cap_fire, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    for (genvar i = 0; i < N_COLS; i++) begin : g_lane
        acc_result_writeback_requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .x          (head[i*ACC_W +: ACC_W]),
            .shift      (shift_lat),
            .use_signed (signed_lat),
            .sat_en     (sat_lat),
            .y          (lane_y[i]),
            .clipped    (clip_vec[i])
        );
    end

    always_comb begin
        packed_row = '0;
        for (int i = 0; i < N_COLS; i++) packed_row[i*OUT_W +: OUT_W] = lane_y[i];
    end

    assign clip_cnt = 16'($countones(clip_vec));
    assign sat_sum  = {1'b0, sat_count} + {1'b0, clip_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_dat   <= '0;
            sat_count <= '0;
        end else begin
            if (pop) begin
                out_vld <= 1'b1;
                out_dat <= UB_W'(packed_row);
            end else if (ub_fire) begin
                out_vld <= 1'b0;
            end
            if (start_acc)  sat_count <= '0;
            else if (pop)   sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
endmodule
